regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, the width of writeback data.
REQ-002 The block SHALL have port clk, input, 1 bit, the clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, the reset; reset is asynchronous and active-high.
REQ-004 The block SHALL have ports req_valid[i], input, 1 bit each, i=0..2 (0=ALU, 1=MEM, 2=MUL), meaning requester i has a writeback pending.
REQ-005 The block SHALL have ports req_rd[i], input, 5 bits each, the destination register of requester i.
REQ-006 The block SHALL have ports req_data[i], input, XLEN bits each, the writeback value of requester i.
REQ-007 The block SHALL have ports req_ready[i], output, 1 bit each, meaning requester i is granted this cycle.
REQ-008 The block SHALL have port wb_en, output, 1 bit, the register-file write enable.
REQ-009 The block SHALL have port wb_reg, output, 5 bits, the register-file write address.
REQ-010 The block SHALL have port wb_data, output, XLEN bits, the register-file write data.
REQ-011 The block SHALL have port issue_en, input, 1 bit, meaning an instruction is dispatched this cycle (scoreboard only).
REQ-012 The block SHALL have port issue_rd, input, 5 bits, the destination of the dispatched instruction (scoreboard only).
REQ-013 The block SHALL have port busy, output, 32 bits, where bit r set means register r has a writeback outstanding (scoreboard only).

Function
REQ-014 Each cycle, at most one req_ready SHALL be asserted, and it SHALL be combinational from req_valid and the priority pointer.
REQ-015 Arbitration SHALL be round-robin: the search starts at pointer ptr (values 0..2) and takes the first valid requester in the order ptr, ptr+1, ptr+2 mod 3.
REQ-016 On a grant to requester g, ptr SHALL become (g+1) mod 3 at the next edge; with no grant, ptr SHALL hold.
REQ-017 A handshake SHALL complete when req_valid[i] and req_ready[i] are both high; requesters hold valid, rd and data stable until then, and a valid once raised is never withdrawn.
REQ-018 Writeback outputs SHALL be registered with one-cycle latency: wb_reg and wb_data take the granted rd and data at the edge, and wb_en is 1 only if there was a grant and rd != 0.
REQ-019 A grant with rd = 0 SHALL complete the handshake but leave wb_en = 0.
REQ-020 With no grant, wb_en SHALL be 0 next cycle, and wb_reg and wb_data SHALL hold their values.
REQ-021 Full throughput SHALL be one writeback per cycle; with all three requesters valid continuously, grants rotate 0,1,2,0,...

Reset
REQ-022 While reset is high: ptr=0, wb_en=0, wb_reg=0, wb_data=0, busy=0, and all req_ready=0.
REQ-023 Reset asserted mid-handshake SHALL discard the transfer; after release, arbitration restarts from requester 0.

Configuration
REQ-024 With macro REGFILE_WB_SCOREBOARD_EN defined, the block SHALL implement the 32-bit busy scoreboard, updated as follows:
- issue_en with issue_rd != 0 sets busy[issue_rd];
- a completed handshake with rd != 0 clears busy[rd];
- when set and clear hit the same register in the same cycle, set wins;
- busy[0] is always 0.
REQ-025 Without the macro, the block SHALL drive busy to constant 0, SHALL ignore issue_en and issue_rd, and SHALL contain no scoreboard flops.

Verification
REQ-026 Only req_valid[1] asserted, rd=5, data=0xDEAD -> req_ready[1] high the same cycle; next cycle wb_en=1, wb_reg=5, wb_data=0xDEAD; ptr=2.
REQ-027 All three valid for 6 cycles from reset -> grant order 0,1,2,0,1,2 and wb_en high for 6 consecutive cycles.
REQ-028 Requester 0 writes rd=0, data=0x1234 -> req_ready[0]=1, next-cycle wb_en=0, and ptr advances to 1.
REQ-029 Scoreboard: issue rd=7, then two cycles later requester 2 writes rd=7 -> busy[7]=1 until the edge after the grant, then 0; issue rd=7 in the same cycle as the grant -> busy[7] stays 1.
REQ-030 Reset pulsed while requesters 1 and 2 are valid with ptr=2 -> all outputs 0 during reset; first grant after release goes to requester 1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter for ALU/MEM/MUL with optional busy scoreboard (REGFILE_WB_SCOREBOARD_EN)
module regfile_wb_arbiter #(
    parameter int XLEN = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           req_valid,
    input  logic [2:0][4:0]      req_rd,
    input  logic [2:0][XLEN-1:0] req_data,
    output logic [2:0]           req_ready,
    output logic                 wb_en,
    output logic [4:0]           wb_reg,
    output logic [XLEN-1:0]      wb_data,
    input  logic                 issue_en,
    input  logic [4:0]           issue_rd,
    output logic [31:0]          busy
);

    logic [1:0] ptr;
    logic [1:0] ord0, ord1, ord2;
    logic       gnt;
    logic [1:0] gnt_idx;
    logic [4:0] gnt_rd;

    // Search order starts at ptr and wraps; first valid requester wins.
    always_comb begin
        ord0      = 2'd0;
        ord1      = 2'd1;
        ord2      = 2'd2;
        gnt       = 1'b0;
        gnt_idx   = 2'd0;
        req_ready = 3'b000;
        case (ptr)
            2'd1: begin
                ord0 = 2'd1;
                ord1 = 2'd2;
                ord2 = 2'd0;
            end
            2'd2: begin
                ord0 = 2'd2;
                ord1 = 2'd0;
                ord2 = 2'd1;
            end
            default: begin
                ord0 = 2'd0;
                ord1 = 2'd1;
                ord2 = 2'd2;
            end
        endcase
        if (req_valid[ord0]) begin
            gnt     = 1'b1;
            gnt_idx = ord0;
        end else if (req_valid[ord1]) begin
            gnt     = 1'b1;
            gnt_idx = ord1;
        end else if (req_valid[ord2]) begin
            gnt     = 1'b1;
            gnt_idx = ord2;
        end
        // No handshake may complete while reset is held.
        if (gnt && !reset) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign gnt_rd = req_rd[gnt_idx];

    // Priority pointer moves just past the winner; holds when idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= 2'd0;
        end else if (gnt) begin
            ptr <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
        end
    end

    // Registered writeback port; rd=0 grants complete but never write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_en   <= 1'b0;
            wb_reg  <= 5'd0;
            wb_data <= '0;
        end else begin
            wb_en <= gnt && (gnt_rd != 5'd0);
            if (gnt) begin
                wb_reg  <= gnt_rd;
                wb_data <= req_data[gnt_idx];
            end
        end
    end

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [31:0] busy_q;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    // Issue sets a bit, completed writeback clears it; set is applied last so it wins.
    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (issue_en && issue_rd != 5'd0) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (gnt && gnt_rd != 5'd0) begin
            clr_mask[gnt_rd] = 1'b1;
        end
    end

    // Scoreboard state; x0 is never tracked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= 32'd0;
        end else begin
            busy_q <= ((busy_q & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
        end
    end

    assign busy = busy_q;
`else
    logic unused_issue;
    assign unused_issue = ^{issue_en, issue_rd};
    assign busy         = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic             clk = 1'b0;
    logic             reset;
    logic [2:0]       req_valid;
    logic [2:0][4:0]  req_rd;
    logic [2:0][63:0] req_data;
    logic [2:0]       req_ready;
    logic             wb_en;
    logic [4:0]       wb_reg;
    logic [63:0]      wb_data;
    logic             issue_en;
    logic [4:0]       issue_rd;
    logic [31:0]      busy;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          m_ptr;
    logic        m_en;
    logic [4:0]  m_reg;
    logic [63:0] m_data;
    bit          m_busy[32];

    regfile_wb_arbiter #(.XLEN(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
        .req_ready(req_ready),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .issue_en(issue_en), .issue_rd(issue_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]       valid;
        logic [2:0][4:0]  rd;
        logic [2:0][63:0] data;
        logic [2:0]       ready;
        logic             en;
        logic [4:0]       wreg;
        logic [63:0]      wdata;
    } vec_t;

    vec_t tbl[8];

    function automatic vec_t mk(logic [2:0] v, logic [4:0] r0, logic [4:0] r1, logic [4:0] r2,
                                logic [63:0] d0, logic [63:0] d1, logic [63:0] d2,
                                logic [2:0] rdy, logic en, logic [4:0] wr, logic [63:0] wd);
        vec_t t;
        t.valid = v;
        t.rd[0] = r0; t.rd[1] = r1; t.rd[2] = r2;
        t.data[0] = d0; t.data[1] = d1; t.data[2] = d2;
        t.ready = rdy; t.en = en; t.wreg = wr; t.wdata = wd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        for (int r = 0; r < 32; r++) b[r] = m_busy[r];
        return b;
    endfunction

    // Asserts reset at the current time, checks reset-state outputs, releases at a negedge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_ready", {61'd0, req_ready}, 64'd0);
        chk("rst_wb_en", {63'd0, wb_en}, 64'd0);
        chk("rst_wb_reg", {59'd0, wb_reg}, 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_busy", {32'd0, busy}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_ready", {61'd0, req_ready}, 64'd0);
        chk("rst_hold_wb_en", {63'd0, wb_en}, 64'd0);
        reset = 1'b0;
        m_ptr = 0; m_en = 0; m_reg = 0; m_data = 0;
        for (int r = 0; r < 32; r++) m_busy[r] = 0;
    endtask

    // One cycle against the model: inputs already driven after a negedge.
    task automatic model_cycle(output int g);
        int idx;
        g = -1;
        for (int k = 0; k < 3; k++) begin
            idx = (m_ptr + k) % 3;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        #1;
        chk("m_ready", {61'd0, req_ready}, (g >= 0) ? (64'd1 << g) : 64'd0);
        if (g >= 0) begin
            m_en   = (req_rd[g] != 0);
            m_reg  = req_rd[g];
            m_data = req_data[g];
            m_ptr  = (g + 1) % 3;
`ifdef REGFILE_WB_SCOREBOARD_EN
            if (req_rd[g] != 0) m_busy[req_rd[g]] = 0;
`endif
        end else begin
            m_en = 0;
        end
`ifdef REGFILE_WB_SCOREBOARD_EN
        if (issue_en && issue_rd != 0) m_busy[issue_rd] = 1;
`endif
        @(posedge clk);
        @(negedge clk);
        chk("m_wb_en", {63'd0, wb_en}, {63'd0, m_en});
        chk("m_wb_reg", {59'd0, wb_reg}, {59'd0, m_reg});
        chk("m_wb_data", wb_data, m_data);
        chk("m_busy", {32'd0, busy}, {32'd0, model_busy()});
        if (g >= 0) req_valid[g] = 1'b0;
    endtask

    initial begin
        int g;
        reset = 1'b1; req_valid = 0; req_rd = '0; req_data = '0; issue_en = 0; issue_rd = 0;
        @(negedge clk);
        do_reset();

        // table-driven vectors from reset (ptr starts at 0)
        tbl[0] = mk(3'b010, 0, 5, 0, 0, 64'hDEAD, 0, 3'b010, 1, 5, 64'hDEAD);
        tbl[1] = mk(3'b011, 3, 9, 0, 64'h33, 64'h99, 0, 3'b001, 1, 3, 64'h33);
        tbl[2] = mk(3'b010, 3, 9, 0, 64'h33, 64'h99, 0, 3'b010, 1, 9, 64'h99);
        tbl[3] = mk(3'b000, 0, 0, 0, 0, 0, 0, 3'b000, 0, 9, 64'h99);
        tbl[4] = mk(3'b001, 0, 0, 0, 64'h1234, 0, 0, 3'b001, 0, 0, 64'h1234);
        tbl[5] = mk(3'b111, 1, 2, 3, 64'h11, 64'h22, 64'h33, 3'b010, 1, 2, 64'h22);
        tbl[6] = mk(3'b101, 1, 2, 3, 64'h11, 64'h22, 64'h33, 3'b100, 1, 3, 64'h33);
        tbl[7] = mk(3'b001, 1, 2, 3, 64'h11, 64'h22, 64'h33, 3'b001, 1, 1, 64'h11);
        for (int i = 0; i < 8; i++) begin
            req_valid = tbl[i].valid; req_rd = tbl[i].rd; req_data = tbl[i].data;
            #1;
            chk($sformatf("tbl%0d_ready", i), {61'd0, req_ready}, {61'd0, tbl[i].ready});
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_wb_en", i), {63'd0, wb_en}, {63'd0, tbl[i].en});
            chk($sformatf("tbl%0d_wb_reg", i), {59'd0, wb_reg}, {59'd0, tbl[i].wreg});
            chk($sformatf("tbl%0d_wb_data", i), wb_data, tbl[i].wdata);
        end
        req_valid = 0;

        // rotation with all three valid
        do_reset();
        for (int i = 0; i < 6; i++) begin
            req_valid = 3'b111;
            for (int r = 0; r < 3; r++) begin
                req_rd[r] = 5'(r + 1 + i);
                req_data[r] = 64'(100 * i + r);
            end
            model_cycle(g);
            chk("rot_order", 64'(g), 64'(i % 3));
            chk("rot_wb_en", {63'd0, wb_en}, 64'd1);
        end
        req_valid = 0;

        // rd=0 grant: handshake but no write, ptr advances to 1
        do_reset();
        req_valid = 3'b001; req_rd = '0; req_data[0] = 64'h1234;
        model_cycle(g);
        chk("rd0_grant", 64'(g), 64'd0);
        chk("rd0_wb_en", {63'd0, wb_en}, 64'd0);
        req_valid = 3'b111; req_rd[0] = 1; req_rd[1] = 2; req_rd[2] = 3;
        model_cycle(g);
        chk("rd0_next_grant", 64'(g), 64'd1);
        req_valid = 0;

`ifdef REGFILE_WB_SCOREBOARD_EN
        // scoreboard set/clear and set-wins collision
        do_reset();
        issue_en = 1; issue_rd = 7;
        model_cycle(g);
        issue_en = 0;
        chk("sb_set", {63'd0, busy[7]}, 64'd1);
        model_cycle(g);
        chk("sb_hold", {63'd0, busy[7]}, 64'd1);
        req_valid = 3'b100; req_rd[2] = 7; req_data[2] = 64'h77;
        #1;
        chk("sb_before_edge", {63'd0, busy[7]}, 64'd1);
        model_cycle(g);
        chk("sb_clear", {63'd0, busy[7]}, 64'd0);
        issue_en = 1; issue_rd = 7;
        model_cycle(g);
        issue_en = 0;
        req_valid = 3'b100; req_rd[2] = 7;
        issue_en = 1; issue_rd = 7;
        model_cycle(g);
        issue_en = 0;
        chk("sb_set_wins", {63'd0, busy[7]}, 64'd1);
        req_valid = 0;
`endif

        // reset mid-handshake with ptr=2, then restart favours requester 1
        do_reset();
        req_valid = 3'b010; req_rd[1] = 4; req_data[1] = 64'h44;
        model_cycle(g);
        req_valid = 3'b110; req_rd[1] = 8; req_data[1] = 64'h88; req_rd[2] = 6; req_data[2] = 64'h66;
        #1;
        chk("r030_pre_ready", {61'd0, req_ready}, 64'b100);
        do_reset();
        model_cycle(g);
        chk("r030_first", 64'(g), 64'd1);
        req_valid = 0;

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < 3; r++) begin
                if (!req_valid[r] && $urandom_range(0, 2) == 0) begin
                    req_valid[r] = 1'b1;
                    req_rd[r] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                    req_data[r] = {$urandom(), $urandom()};
                end
            end
            issue_en = ($urandom_range(0, 1) == 1);
            issue_rd = 5'($urandom_range(0, 31));
            model_cycle(g);
        end
        issue_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
